systolic_tile_scheduler: RTL

Sequencing controller for the SYSTOLIC_ARRAY datapath. It latches the M/K/N matrix sizes on START and walks the output matrix in PE-array-sized tiles. For each tile it drives the clear, operand-read, skew-flush and output-drain phases, generating SRAM addresses and enables. It reports completion with a one-cycle IS_FINISHED_out pulse and replaces ad-hoc top-level sequencing.

---
 rtl/systolic_tile_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_tile_scheduler.sv
// Tile sequencer for the systolic array: walks the output matrix in PE-array-sized tiles,
// driving clear / operand-read / skew-flush / drain phases and the SRAM addresses for each.
module systolic_tile_scheduler #(
    parameter int unsigned PE_ARRAY_NUM_ROWS = 32,
    parameter int unsigned PE_ARRAY_NUM_COLS = 32,
    parameter int unsigned MAX_M_SIZE_LOG2   = 9,
    parameter int unsigned MAX_K_SIZE_LOG2   = 9,
    parameter int unsigned MAX_N_SIZE_LOG2   = 9,
    parameter int unsigned OPND1_SRAM_AWIDTH = 10,
    parameter int unsigned OPND2_SRAM_AWIDTH = 10,
    parameter int unsigned OUT_SRAM_AWIDTH   = 10
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic                         START,
    input  logic                         STALL,
    input  logic [MAX_M_SIZE_LOG2-1:0]   M_SIZE_in,
    input  logic [MAX_K_SIZE_LOG2-1:0]   K_SIZE_in,
    input  logic [MAX_N_SIZE_LOG2-1:0]   N_SIZE_in,
    output logic                         PE_CLEAR_out,
    output logic                         OPND1_RDEN_out,
    output logic [OPND1_SRAM_AWIDTH-1:0] OPND1_ADDR_out,
    output logic                         OPND2_RDEN_out,
    output logic [OPND2_SRAM_AWIDTH-1:0] OPND2_ADDR_out,
    output logic                         OUT_WREN_out,
    output logic [OUT_SRAM_AWIDTH-1:0]   OUT_ADDR_out,
    output logic                         BUSY_out,
    output logic                         IS_FINISHED_out
);

    localparam int unsigned FlushLen = PE_ARRAY_NUM_ROWS + PE_ARRAY_NUM_COLS - 2;
    localparam int unsigned PhaseW   = $clog2(PE_ARRAY_NUM_ROWS + PE_ARRAY_NUM_COLS) + 1;
    localparam int unsigned CntW     = (MAX_K_SIZE_LOG2 > PhaseW) ? MAX_K_SIZE_LOG2 : PhaseW;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StFlush,
        StDrain,
        StDone
    } state_e;

    state_e                       state_q, state_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [MAX_M_SIZE_LOG2-1:0]   m_t_q, m_t_d, mt_last_q, mt_last_d;
    logic [MAX_N_SIZE_LOG2-1:0]   n_t_q, n_t_d, nt_last_q, nt_last_d;
    logic [MAX_K_SIZE_LOG2-1:0]   k_size_q, k_size_d;
    logic [OPND1_SRAM_AWIDTH-1:0] a1_base_q, a1_base_d, a1_q, a1_d;
    logic [OPND2_SRAM_AWIDTH-1:0] a2_base_q, a2_base_d, a2_q, a2_d;
    logic [OUT_SRAM_AWIDTH-1:0]   out_addr_q, out_addr_d;

    // Addresses are kept as wrapping running counters: tile bases step by K, and the output
    // address simply increments across every drain since tiles are visited in row-major order.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_t_d      = m_t_q;
        n_t_d      = n_t_q;
        mt_last_d  = mt_last_q;
        nt_last_d  = nt_last_q;
        k_size_d   = k_size_q;
        a1_base_d  = a1_base_q;
        a2_base_d  = a2_base_q;
        a1_d       = a1_q;
        a2_d       = a2_q;
        out_addr_d = out_addr_q;
        if (!STALL) begin
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        k_size_d   = K_SIZE_in;
                        // ceil(X/R)-1 == floor((X-1)/R) for X >= 1
                        mt_last_d  = MAX_M_SIZE_LOG2'((32'(M_SIZE_in) - 32'd1) / PE_ARRAY_NUM_ROWS);
                        nt_last_d  = MAX_N_SIZE_LOG2'((32'(N_SIZE_in) - 32'd1) / PE_ARRAY_NUM_COLS);
                        m_t_d      = '0;
                        n_t_d      = '0;
                        cnt_d      = '0;
                        a1_base_d  = '0;
                        a2_base_d  = '0;
                        a1_d       = '0;
                        a2_d       = '0;
                        out_addr_d = '0;
                        if ((M_SIZE_in == '0) || (K_SIZE_in == '0) || (N_SIZE_in == '0)) begin
                            state_d = StDone;
                        end else begin
                            state_d = StClear;
                        end
                    end
                end
                StClear: begin
                    a1_d    = a1_base_q;
                    a2_d    = a2_base_q;
                    cnt_d   = '0;
                    state_d = StFeed;
                end
                StFeed: begin
                    a1_d = a1_q + 1'b1;
                    a2_d = a2_q + 1'b1;
                    if (cnt_q == CntW'(k_size_q) - 1'b1) begin
                        cnt_d   = '0;
                        state_d = (FlushLen != 0) ? StFlush : StDrain;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StFlush: begin
                    if (cnt_q == CntW'(FlushLen - 1)) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    out_addr_d = out_addr_q + 1'b1;
                    if (cnt_q == CntW'(PE_ARRAY_NUM_ROWS - 1)) begin
                        cnt_d = '0;
                        if (n_t_q != nt_last_q) begin
                            n_t_d     = n_t_q + 1'b1;
                            a2_base_d = a2_base_q + OPND2_SRAM_AWIDTH'(k_size_q);
                            state_d   = StClear;
                        end else if (m_t_q != mt_last_q) begin
                            n_t_d     = '0;
                            m_t_d     = m_t_q + 1'b1;
                            a1_base_d = a1_base_q + OPND1_SRAM_AWIDTH'(k_size_q);
                            a2_base_d = '0;
                            state_d   = StClear;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            m_t_q      <= '0;
            n_t_q      <= '0;
            mt_last_q  <= '0;
            nt_last_q  <= '0;
            k_size_q   <= '0;
            a1_base_q  <= '0;
            a2_base_q  <= '0;
            a1_q       <= '0;
            a2_q       <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_t_q      <= m_t_d;
            n_t_q      <= n_t_d;
            mt_last_q  <= mt_last_d;
            nt_last_q  <= nt_last_d;
            k_size_q   <= k_size_d;
            a1_base_q  <= a1_base_d;
            a2_base_q  <= a2_base_d;
            a1_q       <= a1_d;
            a2_q       <= a2_d;
            out_addr_q <= out_addr_d;
        end
    end

    // Controls decode straight from the state register; STALL only masks the strobes.
    assign PE_CLEAR_out    = (state_q == StClear) && !STALL;
    assign OPND1_RDEN_out  = (state_q == StFeed) && !STALL;
    assign OPND2_RDEN_out  = (state_q == StFeed) && !STALL;
    assign OUT_WREN_out    = (state_q == StDrain) && !STALL;
    assign IS_FINISHED_out = (state_q == StDone) && !STALL;
    assign BUSY_out        = (state_q != StIdle);
    assign OPND1_ADDR_out  = a1_q;
    assign OPND2_ADDR_out  = a2_q;
    assign OUT_ADDR_out    = out_addr_q;

endmodule
